bn_out_collector: RTL and testbench
===================================

# bn_out_collector

Output-side collector placed directly downstream of the per-row pipelined batch-normalization engines. Each of the PE_ROW_NUM BN lanes delivers results with its own valid strobe and no backpressure. The block buffers each lane in a small FIFO and re-aligns the lanes into one wide word. It then presents that word on a valid/ready stream toward the result store, marking frame boundaries and flagging any lane overflow.

## Interface
- PE_ROW_NUM, 4, number of BN lanes (one per systolic row)
- DATA_WIDTH, 16, width of one lane sample, two's complement
- FIFO_DEPTH, 8, per-lane FIFO depth; power of two, at least 2
- WORDS_PER_FRAME, 16, output words per frame; m_last marks the final word of each frame
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- valid_x_in  input  PE_ROW_NUM  per-lane sample strobe from BN lanes
- x_in  input  PE_ROW_NUM*DATA_WIDTH  lane samples; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- clr_ovf  input  1  synchronous clear of the overflow flags
- m_valid  output  1  output word valid
- m_ready  input  1  downstream accepts the word
- m_data  output  PE_ROW_NUM*DATA_WIDTH  aligned word; same lane packing as x_in
- m_last  output  1  word is index WORDS_PER_FRAME-1 of the current frame
- overflow  output  PE_ROW_NUM  sticky per-lane flag: a sample was dropped

## Operation
- Per-lane FIFO, count width $clog2(FIFO_DEPTH+1).
  - A push occurs on valid_x_in[i] when count < FIFO_DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the sample is dropped and overflow[i] is set.
- Output register holds m_data, m_valid and m_last.
- Load condition: all lane FIFOs are non-empty, and either m_valid is 0 or m_valid && m_ready.
- On load, all lanes pop together and the output register is written with the heads of all lanes.
- If no load occurs but m_valid && m_ready, m_valid clears to 0.
- While m_valid && !m_ready, m_data and m_last hold stable.
- Word counter advances on each handshake (m_valid && m_ready) and wraps from WORDS_PER_FRAME-1 to 0.
  - m_last is registered at load time: 1 when the word being loaded takes index WORDS_PER_FRAME-1.
  - That index accounts for a handshake in the same cycle.
- overflow[i]:
  - Set on a drop.
  - clr_ovf clears all bits.
  - If clr_ovf and a drop on lane i occur in the same cycle, overflow[i] ends at 1 (set wins).
- Lanes never reorder; each lane's output order equals its input order.
- No lane ever pops alone.

## Timing
- Reset (async assert, sync-safe deassert): FIFOs empty, word counter 0; m_valid=0, m_data=0, m_last=0, overflow=0.
- Reset asserted mid-frame discards all buffered samples and restarts at word index 0.
- Latency: the last-arriving lane's valid in cycle t gives m_valid=1 in cycle t+2, when the output register is free.
- Throughput: one word per cycle with m_ready held high and all lanes streaming every cycle.
- A full FIFO with a simultaneous pop accepts the push with no drop; count is unchanged.
- m_ready is ignored while m_valid=0.

## Configuration
- BN_OUT_RELU_EN
  - Defined: at load, each lane value with its sign bit set is replaced by 0; non-negative values pass unchanged.
  - Not defined: values pass bit-exact.
  - Latency and handshake are identical in both builds.

## Test plan
- Aligned stream:
  - Stimulus: all 4 lanes valid for 16 cycles with values lane*0x100+k, m_ready=1.
  - Response: 16 words, first word in cycle 2, word k = {0x030k,0x020k,0x010k,0x000k}, m_last only on k=15, overflow=0.
- Skewed lanes:
  - Stimulus: lane i starts i cycles late, 8 samples each.
  - Response: 8 correctly aligned words; first m_valid appears 2 cycles after lane 3's first valid.
- Backpressure:
  - Stimulus: m_ready=0 for 5 cycles mid-stream.
  - Response: m_data and m_last stable during the stall; no loss while counts ≤ 8.
  - Resume gives a contiguous sequence.
- Overflow:
  - Stimulus: lane 2 silent, lanes 0, 1 and 3 each push 9 samples.
  - Response: overflow=4'b1011 and 9th samples dropped.
  - clr_ovf pulse returns overflow to 0; clr_ovf coincident with a 10th drop on lane 0 leaves overflow[0]=1.
- Reset mid-frame:
  - Stimulus: rst_n low after word 5.
  - Response: all outputs 0; the next frame's m_last is on its 16th word.
- With BN_OUT_RELU_EN:
  - Stimulus: input 16'hFFF0 on lane 1 and 16'h0005 on lane 0.
  - Response: lane 1 outputs 0 and lane 0 outputs 0x0005.
  - Without the macro, 16'hFFF0 passes through unchanged.

Source files
------------

// File: rtl/bn_out_collector.sv
// Per-lane FIFOs realign BN lane outputs into one valid/ready word stream.
// Optional BN_OUT_RELU_EN clamps negative lane values to zero at load.
module bn_out_collector #(
    parameter int PE_ROW_NUM      = 4,
    parameter int DATA_WIDTH      = 16,
    parameter int FIFO_DEPTH      = 8,
    parameter int WORDS_PER_FRAME = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [PE_ROW_NUM-1:0]            valid_x_in,
    input  logic [PE_ROW_NUM*DATA_WIDTH-1:0] x_in,
    input  logic                             clr_ovf,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [PE_ROW_NUM*DATA_WIDTH-1:0] m_data,
    output logic                             m_last,
    output logic [PE_ROW_NUM-1:0]            overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int WC_W  = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam int WW    = PE_ROW_NUM * DATA_WIDTH;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [WC_W-1:0]  LAST_IDX = WC_W'(WORDS_PER_FRAME - 1);

    logic [PE_ROW_NUM-1:0][FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic [PE_ROW_NUM-1:0][PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PE_ROW_NUM-1:0][PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PE_ROW_NUM-1:0][CNT_W-1:0] count_q, count_d;
    logic [PE_ROW_NUM-1:0]            ovf_q, ovf_d;
    logic [WC_W-1:0]                  wc_q, wc_d;
    logic                             m_valid_q, m_valid_d;
    logic                             m_last_q, m_last_d;
    logic [WW-1:0]                    m_data_q, m_data_d;

    logic [PE_ROW_NUM-1:0]                 non_empty;
    logic [PE_ROW_NUM-1:0]                 push;
    logic [PE_ROW_NUM-1:0]                 drop;
    logic [PE_ROW_NUM-1:0][DATA_WIDTH-1:0] head;
    logic [WW-1:0]                         head_word;
    logic                                  hs;
    logic                                  load;

    assign hs = m_valid_q & m_ready;

    always_comb begin
        for (int i = 0; i < PE_ROW_NUM; i++) begin
            non_empty[i] = (count_q[i] != '0);
        end
    end

    // All lanes pop together, so a lane only drains when every lane has data.
    assign load = (&non_empty) & (~m_valid_q | m_ready);

    always_comb begin
        head_word = '0;
        for (int i = 0; i < PE_ROW_NUM; i++) begin
            head[i] = mem_q[i][rd_ptr_q[i]];
`ifdef BN_OUT_RELU_EN
            head_word[i*DATA_WIDTH +: DATA_WIDTH] =
                head[i][DATA_WIDTH-1] ? '0 : head[i];
`else
            head_word[i*DATA_WIDTH +: DATA_WIDTH] = head[i];
`endif
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        push     = '0;
        drop     = '0;
        for (int i = 0; i < PE_ROW_NUM; i++) begin
            push[i] = valid_x_in[i] & ((count_q[i] < FULL_CNT) | load);
            drop[i] = valid_x_in[i] & ~push[i];
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = x_in[i*DATA_WIDTH +: DATA_WIDTH];
                wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
            end
            if (load) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            end
            count_d[i] = count_q[i] + CNT_W'(push[i]) - CNT_W'(load);
        end
    end

    always_comb begin
        wc_d      = wc_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        if (hs) begin
            wc_d      = (wc_q == LAST_IDX) ? '0 : wc_q + WC_W'(1);
            m_valid_d = 1'b0;
        end
        // wc_d already reflects a same-cycle handshake, so it is the new word's index.
        if (load) begin
            m_valid_d = 1'b1;
            m_data_d  = head_word;
            m_last_d  = (wc_d == LAST_IDX);
        end
    end

    always_comb begin
        ovf_d = (clr_ovf ? '0 : ovf_q) | drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= '0;
            wc_q      <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            wc_q      <= wc_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_last   = m_last_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bn_out_collector.sv
// Scoreboard bench for bn_out_collector: directed lane streams, monitor checks words.
// Build with BN_OUT_RELU_EN defined to expect the clamped values.
module tb_bn_out_collector;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int D   = 8;
    localparam int WPF = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    valid_x_in;
    logic [N*DW-1:0] x_in;
    logic            clr_ovf;
    logic            m_valid;
    logic            m_ready;
    logic [N*DW-1:0] m_data;
    logic            m_last;
    logic [N-1:0]    overflow;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int exp_idx = 0;
    logic [N*DW:0] sb[$];

    bn_out_collector #(
        .PE_ROW_NUM(N), .DATA_WIDTH(DW),
        .FIFO_DEPTH(D), .WORDS_PER_FRAME(WPF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_x_in(valid_x_in), .x_in(x_in),
        .clr_ovf(clr_ovf),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef BN_OUT_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [N*DW-1:0] mk(input int base, input int k);
        logic [N*DW-1:0] w;
        for (int i = 0; i < N; i++) w[i*DW +: DW] = relu(16'(base + i*256 + k));
        return w;
    endfunction

    task automatic push_exp(input logic [N*DW-1:0] w);
        sb.push_back({(exp_idx == WPF-1), w});
        exp_idx = (exp_idx + 1) % WPF;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_all(input int base, input int k);
        valid_x_in = '1;
        for (int i = 0; i < N; i++) x_in[i*DW +: DW] = 16'(base + i*256 + k);
    endtask

    task automatic idle();
        valid_x_in = '0;
        x_in = '0;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 100 && sb.size() != 0; c++) step();
        step();
        step();
        check({name, "_drained"}, sb.size(), 0);
        check({name, "_idle"}, m_valid, 0);
    endtask

    always @(negedge clk) begin
        logic [N*DW:0] e;
        if (rst_n && m_valid && m_ready) begin
            hs_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h expected none", m_data);
            end else begin
                e = sb.pop_front();
                check("sb_word", {m_last, m_data}, e);
            end
        end
    end

    initial begin
        int base;
        logic [N*DW+1:0] held;
        logic [N*DW-1:0] w;
        idle();
        clr_ovf = 1'b0;
        m_ready = 1'b1;
        held = '0;
        step();
        check("reset_state", {m_valid, m_last, m_data, overflow}, 0);
        step();
        rst_n = 1'b1;
        step();

        // aligned stream: latency 2, one word per cycle, last on word 15
        for (int k = 0; k < 16; k++) push_exp(mk(0, k));
        base = hs_cnt;
        for (int t = 0; t < 16; t++) begin
            drive_all(0, t);
            step();
            if (t == 0) check("lat_aligned_c1", m_valid, 0);
            if (t == 1) check("lat_aligned_c2", m_valid, 1);
        end
        idle();
        step();
        @(negedge clk);
        #1;
        check("throughput", hs_cnt - base, 16);
        check("ovf_aligned", overflow, 0);
        drain("aligned");

        // skewed lanes: lane i starts i cycles late
        for (int k = 0; k < 8; k++) push_exp(mk(16'h1000, k));
        for (int t = 0; t < 11; t++) begin
            for (int i = 0; i < N; i++) begin
                valid_x_in[i] = (t >= i && t < i + 8);
                x_in[i*DW +: DW] = 16'(16'h1000 + i*256 + (t - i));
            end
            step();
            if (t == 3) check("lat_skew_c4", m_valid, 0);
            if (t == 4) check("lat_skew_c5", m_valid, 1);
        end
        idle();
        drain("skew");

        // backpressure: m_ready low for cycles 3..7
        for (int k = 0; k < 8; k++) push_exp(mk(16'h2000, k));
        for (int t = 0; t < 8; t++) begin
            drive_all(16'h2000, t);
            m_ready = (t < 3);
            if (t == 3) held = {m_valid, m_last, m_data};
            if (t > 3) check("stall_hold", {m_valid, m_last, m_data}, held);
            step();
        end
        idle();
        m_ready = 1'b1;
        drain("stall");

        // overflow: lane 2 silent, 9 samples on lanes 0,1,3
        for (int t = 0; t < 9; t++) begin
            valid_x_in = 4'b1011;
            for (int i = 0; i < N; i++) x_in[i*DW +: DW] = 16'(16'h4000 + i*256 + t);
            step();
            if (t == 7) check("ovf_full_no_drop", overflow, 0);
        end
        idle();
        check("ovf_set", overflow, 4'b1011);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("ovf_clr", overflow, 0);
        valid_x_in = 4'b0001;
        x_in[DW-1:0] = 16'h40FF;
        clr_ovf = 1'b1;
        step();
        idle();
        clr_ovf = 1'b0;
        check("ovf_set_wins", overflow, 4'b0001);
        for (int k = 0; k < 8; k++) push_exp(mk(16'h4000, k));
        for (int t = 0; t < 8; t++) begin
            valid_x_in = 4'b0100;
            x_in[2*DW +: DW] = 16'(16'h4200 + t);
            step();
        end
        idle();
        drain("ovf");

        // reset mid-frame after the sixth word of this burst
        for (int k = 0; k < 8; k++) push_exp(mk(16'h5000, k));
        base = hs_cnt;
        for (int t = 0; t < 30; t++) begin
            if (hs_cnt - base >= 6) break;
            if (t < 8) drive_all(16'h5000, t);
            else idle();
            step();
        end
        check("rst_pre_words", hs_cnt - base, 6);
        rst_n = 1'b0;
        idle();
        #1;
        check("rst_async", {m_valid, m_last, m_data, overflow}, 0);
        sb.delete();
        exp_idx = 0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rst_after", {m_valid, overflow}, 0);
        for (int k = 0; k < 16; k++) push_exp(mk(16'h6000, k));
        for (int t = 0; t < 16; t++) begin
            drive_all(16'h6000, t);
            step();
        end
        idle();
        drain("post_rst");

        // sign handling: lanes {7FFF, 8000, FFF0, 0005}
`ifdef BN_OUT_RELU_EN
        w = {16'h7FFF, 16'h0000, 16'h0000, 16'h0005};
`else
        w = {16'h7FFF, 16'h8000, 16'hFFF0, 16'h0005};
`endif
        push_exp(w);
        valid_x_in = '1;
        x_in = {16'h7FFF, 16'h8000, 16'hFFF0, 16'h0005};
        step();
        idle();
        drain("relu");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
